exe_muldiv_unit: RTL
====================

EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values: even, 8..64).
REQ-002 The module SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have input flush, 1 bit: cancels any in-flight operation (driven on wb exception/ertn/refetch).
REQ-005 The module SHALL have input in_valid, 1 bit: an operation request is present.
REQ-006 The module SHALL have output in_ready, 1 bit: the unit can accept a request this cycle.
REQ-007 The module SHALL have input op, 3 bits: operation select. 000 MUL, 001 MULH, 010 MULHU, 100 DIV, 101 MOD, 110 DIVU, 111 MODU, 011 reserved.
REQ-008 The module SHALL have inputs src1 and src2, WIDTH bits each: dividend/multiplicand and divisor/multiplier.
REQ-009 The module SHALL have output out_valid, 1 bit: the result is available.
REQ-010 The module SHALL have input out_ready, 1 bit: the consumer takes the result.
REQ-011 The module SHALL have output result, WIDTH bits: the operation result.
REQ-012 The module SHALL have output busy, 1 bit: high in the DIV or DONE state.

Function
REQ-013 The module SHALL implement states IDLE, DIV and DONE.
REQ-014 in_ready SHALL equal (state==IDLE) & ~flush.
REQ-015 A request SHALL be accepted only in a cycle where in_valid & in_ready is high; op, src1 and src2 are captured in that cycle.
REQ-016 An accepted MUL, MULH, MULHU or reserved op SHALL go IDLE->DONE, with out_valid high on the next cycle (latency 1).
REQ-017 MUL SHALL return the low WIDTH bits of the 2*WIDTH product.
REQ-018 MULH SHALL return the high WIDTH bits of the signed x signed product.
REQ-019 MULHU SHALL return the high WIDTH bits of the unsigned x unsigned product.
REQ-020 The reserved op SHALL return 0.
REQ-021 An accepted divide op SHALL go IDLE->DIV.
REQ-022 In DIV the module SHALL run a radix-2 restoring iteration on operand magnitudes, one bit per cycle, for WIDTH cycles, then enter DONE.
REQ-023 out_valid SHALL assert WIDTH+1 cycles after acceptance (33 for WIDTH=32).
REQ-024 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL reload at each acceptance.
REQ-025 For signed ops, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of src1 (truncating division).
REQ-026 Signed MIN / -1 SHALL give quotient MIN and remainder 0 (WIDTH-bit wrap).
REQ-027 A divisor of 0 SHALL give quotient all-ones and remainder src1, for both signed and unsigned ops.
REQ-028 In DONE, out_valid and result SHALL hold stable until out_ready is high; on that cycle the state SHALL go to IDLE.
REQ-029 No new request SHALL be accepted in the cycle out_ready completes; the next acceptance is one cycle later.
REQ-030 flush in any state SHALL force IDLE on the next edge and drop out_valid to 0 on that edge; no result is produced for the cancelled op.
REQ-031 flush SHALL take priority over in_valid, out_ready and DIV completion in the same cycle.
REQ-032 busy SHALL be 1 exactly when state is DIV or DONE.

Reset
REQ-033 Reset SHALL take effect at a rising clk edge with reset high, from any state including mid-DIV.
REQ-034 After reset: state IDLE, out_valid 0, result 0, busy 0, in_ready 1 (once reset and flush are low), counter 0.
REQ-035 Reset SHALL have priority over flush and all handshakes.

Configuration
REQ-036 The macro MULDIV_DIVZERO_FAST_EN SHALL select the divide-by-zero latency.
REQ-037 With MULDIV_DIVZERO_FAST_EN defined, a divide op accepted with src2==0 SHALL go IDLE->DONE (latency 1), with the result per REQ-027.
REQ-038 Without MULDIV_DIVZERO_FAST_EN, a divide by zero SHALL take the full WIDTH+1 latency, with the same result values.

Verification (WIDTH=32)
REQ-039 src1=0xFFFFFFFF, src2=2: MUL -> 0xFFFFFFFE; MULH -> 0xFFFFFFFF; MULHU -> 0x00000001; each with out_valid one cycle after acceptance.
REQ-040 DIV with -7 and 2 -> 0xFFFFFFFD; MOD with -7 and 2 -> 0xFFFFFFFF; DIVU with 0xFFFFFFF9 and 2 -> 0x7FFFFFFC; each with out_valid 33 cycles after acceptance.
REQ-041 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; MOD with the same operands -> 0.
REQ-042 DIVU 5/0 -> 0xFFFFFFFF and MODU 5/0 -> 5; latency 1 with the macro defined, 33 without.
REQ-043 flush asserted in the 10th DIV cycle -> out_valid never asserts, in_ready is 1 the next cycle, and a following DIVU 100/7 returns 14.
REQ-044 out_ready held low for 5 cycles in DONE -> result and out_valid stay stable, then clear in the cycle after out_ready rises; reset asserted mid-DIV -> all outputs per REQ-034.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: multiply/divide execution unit.
//   Multiplies (MUL/MULH/MULHU, reserved op) complete one cycle after
//   acceptance. Divides (DIV/MOD/DIVU/MODU) run a radix-2 restoring
//   iteration on operand magnitudes, one bit per cycle, and present the
//   result WIDTH+1 cycles after acceptance.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   flush          : cancel any in-flight operation
//   in_valid/ready : request handshake; op, src1, src2 captured on accept
//   op[2:0]        : 000 MUL, 001 MULH, 010 MULHU, 011 reserved (returns 0),
//                    100 DIV, 101 MOD, 110 DIVU, 111 MODU
//   out_valid/ready: result handshake; result held stable until taken
//   busy           : high while dividing or holding a result
// Build option:
//   MULDIV_DIVZERO_FAST_EN : a divide by zero completes with latency 1
//                            instead of running the full iteration.
module exe_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_rem_op;
  logic             r_divzero;

  logic             w_accept;
  logic             w_div_zero;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_hi_s;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_nrem;
  logic [WIDTH-1:0] w_nquo;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign in_ready   = (r_state == S_IDLE) & ~flush;
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state == S_DIV) | (r_state == S_DONE);
  assign result     = r_result;
  assign w_accept   = in_valid & in_ready;
  assign w_div_zero = (src2 == '0);

  // One unsigned multiplier serves both high-half flavours: the signed high
  // half is the unsigned one corrected by the two sign-weighted cross terms.
  assign w_prod = {{WIDTH{1'b0}}, src1} * {{WIDTH{1'b0}}, src2};
  assign w_hi_s = w_prod[2*WIDTH-1:WIDTH]
                - (src1[WIDTH-1] ? src2 : '0)
                - (src2[WIDTH-1] ? src1 : '0);

  always_comb begin
    w_mul_res = '0;
    case (op[1:0])
      2'b00:   w_mul_res = w_prod[WIDTH-1:0];
      2'b01:   w_mul_res = w_hi_s;
      2'b10:   w_mul_res = w_prod[2*WIDTH-1:WIDTH];
      default: w_mul_res = '0;
    endcase
  end

  // op[1] set means unsigned divide; only signed ops take magnitudes.
  assign w_neg1 = ~op[1] & src1[WIDTH-1];
  assign w_neg2 = ~op[1] & src2[WIDTH-1];
  assign w_mag1 = w_neg1 ? ('0 - src1) : src1;
  assign w_mag2 = w_neg2 ? ('0 - src2) : src2;

  // Restoring step: the dividend shifts out of r_quo into the partial
  // remainder while quotient bits shift in from the bottom.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};
  assign w_ge    = ~w_trial[WIDTH];
  assign w_nrem  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_nquo  = {r_quo[WIDTH-2:0], w_ge};

  // MIN / -1 needs no special case: magnitude quotient 2^(WIDTH-1) negates
  // back onto itself under WIDTH-bit wrap.
  assign w_q_fin = r_divzero ? '1     : (r_qneg ? ('0 - w_nquo) : w_nquo);
  assign w_r_fin = r_divzero ? r_src1 : (r_rneg ? ('0 - w_nrem) : w_nrem);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_result  <= '0;
      r_src1    <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_rem_op  <= 1'b0;
      r_divzero <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= CW'(WIDTH);
            if (!op[2]) begin
              r_result <= w_mul_res;
              r_state  <= S_DONE;
            end
`ifdef MULDIV_DIVZERO_FAST_EN
            else if (w_div_zero) begin
              r_result <= op[0] ? src1 : '1;
              r_state  <= S_DONE;
            end
`endif
            else begin
              r_src1    <= src1;
              r_div     <= w_mag2;
              r_quo     <= w_mag1;
              r_rem     <= '0;
              r_qneg    <= w_neg1 ^ w_neg2;
              r_rneg    <= w_neg1;
              r_rem_op  <= op[0];
              r_divzero <= w_div_zero;
              r_state   <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_nrem;
          r_quo <= w_nquo;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result <= r_rem_op ? w_r_fin : w_q_fin;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
